sdram_burst_port: RTL and testbench
===================================

Name: sdram_burst_port

Overview:
- Next-generation SDRAM data port for the SDRAM controller.
- Replaces the single-beat data register, dq port and mux with one parametrised block running on a single clock.
- Drives write bursts onto the bidirectional dq bus with per-byte masks.
- Captures read bursts after a configurable CAS latency into a read FIFO with a valid/ready handshake, and reports protocol errors and overflow.

Parameters:
- DATA_W, 32, dq / user data width in bits (multiple of 8).
- DQM_W, DATA_W/8, byte-mask width.
- CAS_LAT, 2, SDRAM CAS latency in clk0 cycles (legal: 2 or 3).
- BURST_LEN, 4, beats per burst (legal: 1, 2, 4, 8).
- FIFO_DEPTH, 8, read FIFO entries (power of 2, >= BURST_LEN).

Ports:
- clk0  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_start  in  1  pulse: WRITE command issued to command register this cycle.
- wr_data  in  DATA_W  current write beat.
- wr_mask  in  DQM_W  current beat byte mask (1 = masked).
- wr_data_ack  out  1  current wr_data/wr_mask consumed at this edge.
- rd_start  in  1  pulse: READ command issued to command register this cycle.
- rd_data  out  DATA_W  read FIFO head.
- rd_valid  out  1  FIFO not empty.
- rd_ready  in  1  consumer pops head when rd_valid & rd_ready.
- fifo_level  out  log2(FIFO_DEPTH)+1  FIFO occupancy.
- busy  out  1  burst in progress; starts ignored.
- cmd_err  out  1  one-cycle pulse, start dropped.
- overflow  out  1  sticky: a read beat was dropped because the FIFO was full.
- dqm  out  DQM_W  SDRAM byte masks (registered).
- dq  inout  DATA_W  SDRAM data bus; high-Z when not driving.

Behaviour:
- Reset (async): state IDLE, dq high-Z, dqm all ones, wr_data_ack 0, busy 0, cmd_err 0, overflow 0, FIFO empty (rd_valid 0, fifo_level 0), all counters 0.
- Timing reference: start pulse in cycle T; the matching command reaches SDRAM pins at T+1.
- States: IDLE, WR, RD_WAIT, RD_CAP.
- IDLE + wr_start: consume beat 0 (wr_data_ack=1 in T); go to WR.
- WR: wr_data_ack=1 for beats 1..BURST_LEN-1 (cycles T+1..T+BURST_LEN-1).
  - Registered beat k drives dq, with dqm=mask_k, in cycle T+1+k.
  - After the last beat is driven (T+BURST_LEN), return to IDLE.
  - dq high-Z and dqm all ones from T+BURST_LEN+1.
- IDLE + rd_start: go to RD_WAIT for CAS_LAT cycles; dqm=0 from T+1 until the last beat is captured.
- RD_CAP: sample dq at the edges ending cycles T+1+CAS_LAT+k, k=0..BURST_LEN-1.
  - Each sample is written to the FIFO at that edge, so beat 0 shows as rd_valid in T+2+CAS_LAT.
  - Return to IDLE after the last beat.
  - dq is never driven in RD_WAIT or RD_CAP.
- BURST_LEN=1: WR lasts zero extra cycles (single ack in T); RD_CAP is one cycle.
- busy = state != IDLE. It deasserts in the cycle the state returns to IDLE, so back-to-back starts are accepted from that cycle.
- Any start while busy: ignored, cmd_err pulses in that cycle.
- wr_start & rd_start in IDLE together: write accepted, read dropped, cmd_err pulses.
- FIFO:
  - A push and a pop in the same cycle leave the level unchanged.
  - A push when full (no simultaneous pop) drops the beat and sets overflow.
  - A push when full with a simultaneous pop is accepted.
  - Pointers wrap modulo FIFO_DEPTH.
  - rd_data is the head entry; its value when empty is don't-care.
- overflow clears only on reset.
- Reset mid-burst: dq released and dqm forced all ones immediately; the partial burst is discarded, FIFO contents are lost, no ack/valid follows.

Test Plan:
- Reset, then wr_start with beats 0xA0A0_0001..0xA0A0_0004, mask 0x0 on beats 0, 1 and 3, 0x3 on beat 2 -> wr_data_ack high T..T+3; dq shows the beats T+1..T+4; dqm 0,0,3,0; dq Z and dqm F at T+5; busy low at T+4.
- CAS_LAT=2, rd_start at T, model drives 0x11,0x22,0x33,0x44 on dq in cycles T+3..T+6 -> rd_valid rises at T+4; rd_ready held high pops 0x11..0x44 in order; fifo_level returns to 0.
- CAS_LAT=3 rerun of the read case -> first capture shifts one cycle later (rd_valid at T+5).
- FIFO_DEPTH=8, rd_ready=0, three read bursts back-to-back -> fifo_level 8 after two bursts; third burst's 4 beats dropped; overflow=1 and stays 1 until reset.
- wr_start during read burst, and simultaneous wr_start+rd_start in IDLE -> cmd_err one-cycle pulse each time; first: read unaffected; second: only the write executes.
- Assert reset at write beat 2 -> dq high-Z and dqm F in the same cycle; state IDLE, no further acks; next wr_start after release behaves normally.

Source files
------------

// File: rtl/sdram_burst_port.sv
// SDRAM data port: write bursts onto dq with byte masks, read bursts
// captured after CAS latency into a valid/ready read FIFO.
module sdram_burst_port #(
    parameter int DATA_W     = 32,
    parameter int DQM_W      = DATA_W / 8,
    parameter int CAS_LAT    = 2,
    parameter int BURST_LEN  = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk0,
    input  logic                          reset,
    input  logic                          wr_start,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic [DQM_W-1:0]              wr_mask,
    output logic                          wr_data_ack,
    input  logic                          rd_start,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy,
    output logic                          cmd_err,
    output logic                          overflow,
    output logic [DQM_W-1:0]              dqm,
    inout  wire  [DATA_W-1:0]             dq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(BURST_LEN + CAS_LAT + 1);

    typedef enum logic [1:0] {IDLE, WR, RD_WAIT, RD_CAP} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] dq_q;
    logic [DQM_W-1:0]  dqm_q, dqm_d;
    logic              oe_q;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wptr_q, rptr_q;
    logic [LW-1:0]     level_q;
    logic              ovf_q;
    logic              push, pop, full, push_ok;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_data_ack = 1'b0;
        cmd_err     = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (wr_start) begin
                    wr_data_ack = 1'b1;
                    cmd_err     = rd_start;
                    if (BURST_LEN > 1) begin
                        state_d = WR;
                        cnt_d   = CW'(1);
                    end
                end else if (rd_start) begin
                    state_d = RD_WAIT;
                end
            end
            WR: begin
                wr_data_ack = 1'b1;
                cmd_err     = wr_start | rd_start;
                cnt_d       = cnt_q + CW'(1);
                if (cnt_q == CW'(BURST_LEN - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            RD_WAIT: begin
                cmd_err = wr_start | rd_start;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(CAS_LAT - 1)) begin
                    state_d = RD_CAP;
                    cnt_d   = '0;
                end
            end
            RD_CAP: begin
                cmd_err = wr_start | rd_start;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(BURST_LEN - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Masks follow the state the pins will be in next cycle.
    always_comb begin
        dqm_d = '1;
        if (wr_data_ack) begin
            dqm_d = wr_mask;
        end else if (state_d == RD_WAIT || state_d == RD_CAP) begin
            dqm_d = '0;
        end
    end

    always_ff @(posedge clk0 or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dq_q    <= '0;
            dqm_q   <= '1;
            oe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dqm_q   <= dqm_d;
            oe_q    <= wr_data_ack;
            if (wr_data_ack) begin
                dq_q <= wr_data;
            end
        end
    end

    assign dq   = oe_q ? dq_q : 'z;
    assign dqm  = dqm_q;
    assign busy = (state_q != IDLE);

    assign push    = (state_q == RD_CAP);
    assign pop     = rd_valid & rd_ready;
    assign full    = (level_q == LW'(FIFO_DEPTH));
    assign push_ok = push & (~full | pop);

    always_ff @(posedge clk0) begin
        if (push_ok) begin
            mem[wptr_q] <= dq;
        end
    end

    always_ff @(posedge clk0 or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (push_ok) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            level_q <= level_q + LW'(push_ok) - LW'(pop);
            if (push & full & ~pop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign rd_data    = mem[rptr_q];
    assign rd_valid   = (level_q != '0);
    assign fifo_level = level_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_sdram_burst_port.sv
// Scoreboard bench for sdram_burst_port: CAS_LAT=2 main instance and
// a CAS_LAT=3 instance for read-latency checks.
module tb_sdram_burst_port;

    logic        clk0 = 1'b0;
    logic        reset;
    logic        wr_start, rd_start, rd_ready;
    logic [31:0] wr_data;
    logic [3:0]  wr_mask;
    logic        wr_data_ack, rd_valid, busy, cmd_err, overflow;
    logic [31:0] rd_data;
    logic [3:0]  fifo_level, dqm;
    wire  [31:0] dq;
    logic        drv_en;
    logic [31:0] drv_data;

    logic        wr_start3, rd_start3, rd_ready3;
    logic [31:0] wr_data3;
    logic [3:0]  wr_mask3;
    logic        wr_data_ack3, rd_valid3, busy3, cmd_err3, overflow3;
    logic [31:0] rd_data3;
    logic [3:0]  fifo_level3, dqm3;
    wire  [31:0] dq3;
    logic        drv3_en;
    logic [31:0] drv3_data;

    int nvec = 0;
    int nerr = 0;
    logic [35:0] exp_wr[$];
    logic [31:0] exp_rd[$];
    logic [31:0] exp_rd3[$];
    logic [35:0] e_wr;
    logic [31:0] e_rd;

    localparam logic [31:0] REL = 32'hFFFF_FFFF;

    always #5 clk0 = ~clk0;

    // Released bus reads back as all ones; no test beat is all ones.
    pullup (dq[0]);  pullup (dq[1]);  pullup (dq[2]);  pullup (dq[3]);
    pullup (dq[4]);  pullup (dq[5]);  pullup (dq[6]);  pullup (dq[7]);
    pullup (dq[8]);  pullup (dq[9]);  pullup (dq[10]); pullup (dq[11]);
    pullup (dq[12]); pullup (dq[13]); pullup (dq[14]); pullup (dq[15]);
    pullup (dq[16]); pullup (dq[17]); pullup (dq[18]); pullup (dq[19]);
    pullup (dq[20]); pullup (dq[21]); pullup (dq[22]); pullup (dq[23]);
    pullup (dq[24]); pullup (dq[25]); pullup (dq[26]); pullup (dq[27]);
    pullup (dq[28]); pullup (dq[29]); pullup (dq[30]); pullup (dq[31]);
    assign dq  = drv_en  ? drv_data  : 'z;
    assign dq3 = drv3_en ? drv3_data : 'z;

    sdram_burst_port #(.CAS_LAT(2)) u_dut (
        .clk0(clk0), .reset(reset),
        .wr_start(wr_start), .wr_data(wr_data), .wr_mask(wr_mask),
        .wr_data_ack(wr_data_ack),
        .rd_start(rd_start), .rd_data(rd_data), .rd_valid(rd_valid),
        .rd_ready(rd_ready), .fifo_level(fifo_level),
        .busy(busy), .cmd_err(cmd_err), .overflow(overflow),
        .dqm(dqm), .dq(dq)
    );

    sdram_burst_port #(.CAS_LAT(3)) u_dut3 (
        .clk0(clk0), .reset(reset),
        .wr_start(wr_start3), .wr_data(wr_data3), .wr_mask(wr_mask3),
        .wr_data_ack(wr_data_ack3),
        .rd_start(rd_start3), .rd_data(rd_data3), .rd_valid(rd_valid3),
        .rd_ready(rd_ready3), .fifo_level(fifo_level3),
        .busy(busy3), .cmd_err(cmd_err3), .overflow(overflow3),
        .dqm(dqm3), .dq(dq3)
    );

    task automatic chk(input string name, input logic [35:0] act,
                       input logic [35:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk0);
        #1;
    endtask

    task automatic neg;
        @(negedge clk0);
    endtask

    // Monitor: pops expectations whenever the DUT presents a beat.
    always @(negedge clk0) begin
        if (!reset) begin
            if (!drv_en && dq != REL) begin
                if (exp_wr.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL wr_extra: got %h, expected released", dq);
                end else begin
                    e_wr = exp_wr.pop_front();
                    chk("wr_beat", {dqm, dq}, e_wr);
                end
            end
            if (rd_valid && rd_ready) begin
                if (exp_rd.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL rd_extra: got %h, expected none", rd_data);
                end else begin
                    e_rd = exp_rd.pop_front();
                    chk("rd_beat", rd_data, e_rd);
                end
            end
            if (rd_valid3 && rd_ready3) begin
                if (exp_rd3.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL rd3_extra: got %h, expected none", rd_data3);
                end else begin
                    e_rd = exp_rd3.pop_front();
                    chk("rd3_beat", rd_data3, e_rd);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            step;
            wr_start  = 1'b0;
            rd_start  = 1'b0;
            drv_en    = 1'b0;
            rd_start3 = 1'b0;
            drv3_en   = 1'b0;
        end
        neg;
    endtask

    task automatic write_burst(input logic [3:0][31:0] d,
                               input logic [3:0][3:0] m,
                               input bit with_rd, input int rst_beat);
        for (int k = 0; k < 4; k++) begin
            step;
            wr_start = (k == 0);
            rd_start = with_rd && (k == 0);
            wr_data  = d[k];
            wr_mask  = m[k];
            if (k == rst_beat) begin
                reset = 1'b1;
                neg;
                chk("rst_dq", dq == REL, 1'b1);
                chk("rst_dqm", dqm, 4'hF);
                chk("rst_ack", wr_data_ack, 1'b0);
                chk("rst_busy", busy, 1'b0);
                chk("rst_ovf", overflow, 1'b0);
                chk("rst_lvl", fifo_level, 4'd0);
                step;
                reset    = 1'b0;
                wr_start = 1'b0;
                neg;
                chk("post_rst_ack", wr_data_ack, 1'b0);
                chk("post_rst_dq", dq == REL, 1'b1);
                return;
            end
            if (rst_beat < 0 || k < rst_beat - 1) begin
                exp_wr.push_back({m[k], d[k]});
            end
            neg;
            chk("wr_ack", wr_data_ack, 1'b1);
            chk("wr_busy", busy, k != 0);
            chk("wr_cmd_err", cmd_err, with_rd && (k == 0));
        end
        step;
        wr_start = 1'b0;
        wr_data  = 32'h0;
        wr_mask  = 4'h0;
        neg;
        chk("wr_ack_end", wr_data_ack, 1'b0);
        chk("wr_busy_end", busy, 1'b0);
        step;
        neg;
        chk("wr_dq_rel", dq == REL, 1'b1);
        chk("wr_dqm_rel", dqm, 4'hF);
    endtask

    // Issues a CAS_LAT=2 read at cycle 0 and models the SDRAM for 7 cycles.
    task automatic read_burst(input logic [3:0][31:0] v, input bit store,
                              input bit timing, input bit clash,
                              input int lvl0);
        for (int c = 0; c < 7; c++) begin
            step;
            rd_start = (c == 0);
            wr_start = clash && (c == 2);
            wr_data  = 32'hDEAD_BEE0;
            wr_mask  = 4'h0;
            drv_en   = (c >= 3);
            if (c >= 3) begin
                drv_data = v[c-3];
            end
            if (c == 0 && store) begin
                for (int i = 0; i < 4; i++) exp_rd.push_back(v[i]);
            end
            neg;
            if (c == 0) begin
                chk("rd_busy0", busy, 1'b0);
                chk("rd_cmd_err0", cmd_err, 1'b0);
                chk("rd_dqm0", dqm, 4'hF);
                if (lvl0 >= 0) chk("rd_lvl0", fifo_level, lvl0[3:0]);
            end else begin
                chk("rd_dqm", dqm, 4'h0);
            end
            if (clash && c == 2) begin
                chk("clash_err", cmd_err, 1'b1);
                chk("clash_ack", wr_data_ack, 1'b0);
            end
            if (clash && c == 3) chk("clash_err_end", cmd_err, 1'b0);
            if (timing && c == 3) chk("rd_valid_early", rd_valid, 1'b0);
            if (timing && c == 4) chk("rd_valid_rise", rd_valid, 1'b1);
        end
    endtask

    task automatic read_cas3(input logic [3:0][31:0] v);
        for (int c = 0; c < 8; c++) begin
            step;
            rd_start3 = (c == 0);
            drv3_en   = (c >= 4);
            if (c >= 4) begin
                drv3_data = v[c-4];
            end
            if (c == 0) begin
                for (int i = 0; i < 4; i++) exp_rd3.push_back(v[i]);
            end
            neg;
            if (c == 0) chk("c3_busy0", busy3, 1'b0);
            if (c == 1) chk("c3_dqm", dqm3, 4'h0);
            if (c == 2) chk("c3_err_ack", {cmd_err3, wr_data_ack3}, 2'b00);
            if (c == 4) chk("c3_valid_early", rd_valid3, 1'b0);
            if (c == 5) chk("c3_valid_rise", rd_valid3, 1'b1);
        end
        step;
        drv3_en   = 1'b0;
        rd_start3 = 1'b0;
        neg;
        chk("c3_busy_end", busy3, 1'b0);
        step;
        neg;
        chk("c3_lvl_ovf", {overflow3, fifo_level3}, 5'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        wr_start  = 1'b0;
        rd_start  = 1'b0;
        rd_ready  = 1'b0;
        wr_data   = 32'h0;
        wr_mask   = 4'h0;
        drv_en    = 1'b0;
        drv_data  = 32'h0;
        wr_start3 = 1'b0;
        rd_start3 = 1'b0;
        rd_ready3 = 1'b1;
        wr_data3  = 32'h0;
        wr_mask3  = 4'h0;
        drv3_en   = 1'b0;
        drv3_data = 32'h0;

        neg;
        chk("reset_dq", dq == REL, 1'b1);
        chk("reset_dqm", dqm, 4'hF);
        chk("reset_flags", {wr_data_ack, busy, cmd_err, overflow, rd_valid},
            5'b0);
        chk("reset_lvl", fifo_level, 4'd0);
        chk("reset_dqm3", dqm3, 4'hF);
        step;
        reset = 1'b0;

        write_burst({32'hA0A0_0004, 32'hA0A0_0003, 32'hA0A0_0002,
                     32'hA0A0_0001}, {4'h0, 4'h3, 4'h0, 4'h0}, 1'b0, -1);
        idle(1);

        rd_ready = 1'b1;
        read_burst({32'h44, 32'h33, 32'h22, 32'h11}, 1'b1, 1'b1, 1'b0, 0);
        idle(2);
        chk("rd_lvl_drained", fifo_level, 4'd0);

        read_burst({32'h88, 32'h77, 32'h66, 32'h55}, 1'b1, 1'b1, 1'b1, 0);
        idle(2);
        chk("clash_lvl", fifo_level, 4'd0);

        write_burst({32'hB0B0_0004, 32'hB0B0_0003, 32'hB0B0_0002,
                     32'hB0B0_0001}, {4'h8, 4'h4, 4'h2, 4'h1}, 1'b1, -1);
        idle(1);
        chk("dual_start_no_rd", {rd_valid, fifo_level}, 5'd0);

        read_cas3({32'hC4, 32'hC3, 32'hC2, 32'hC1});

        rd_ready = 1'b0;
        read_burst({32'h104, 32'h103, 32'h102, 32'h101}, 1'b1, 1'b0, 1'b0, 0);
        read_burst({32'h208, 32'h207, 32'h206, 32'h205}, 1'b1, 1'b0, 1'b0, 4);
        read_burst({32'h30C, 32'h30B, 32'h30A, 32'h309}, 1'b0, 1'b0, 1'b0, 8);
        idle(1);
        chk("ovf_lvl", fifo_level, 4'd8);
        chk("ovf_set", overflow, 1'b1);
        rd_ready = 1'b1;
        idle(10);
        chk("ovf_drained", fifo_level, 4'd0);
        chk("ovf_sticky", overflow, 1'b1);

        write_burst({32'hC0C0_0004, 32'hC0C0_0003, 32'hC0C0_0002,
                     32'hC0C0_0001}, {4'h0, 4'h0, 4'h0, 4'h0}, 1'b0, 2);
        idle(1);
        write_burst({32'hD0D0_0004, 32'hD0D0_0003, 32'hD0D0_0002,
                     32'hD0D0_0001}, {4'h5, 4'hA, 4'h0, 4'hF}, 1'b0, -1);
        idle(2);

        chk("wr_queue_empty", exp_wr.size(), 0);
        chk("rd_queue_empty", exp_rd.size(), 0);
        chk("rd3_queue_empty", exp_rd3.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
